// File: rtl/mul_sched_pkg.sv
// mul_sched_pkg: shared widths, state encoding and step-counter sizing for
// the two-requester shift-add multiplier scheduler.
package mul_sched_pkg;

  localparam int D_W         = 8;
  localparam int K_W         = 3;
  localparam int OUT_W       = 11;
  localparam int CALC_CYCLES = 3;

  // Step counter is wide enough to index a power-of-two partial-product table.
  localparam int STEP_W = $clog2(CALC_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/mul_shift_core.sv
// mul_shift_core: holds the captured operands, the accumulator and the step
// counter, and performs one shift-add per CALC cycle.
// With MUL_SCHED_ZERO_SKIP_EN defined, it also flags a zero operand so the
// scheduler can cut the calculation short.
module mul_shift_core
  import mul_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             step_en,
  input  logic [D_W-1:0]   d,
  input  logic [K_W-1:0]   k,
  output logic [OUT_W-1:0] sum,
`ifdef MUL_SCHED_ZERO_SKIP_EN
  output logic             zero_op,
`endif
  output logic             last_step
);

  localparam int PP_N = 1 << STEP_W;

  logic [D_W-1:0]    d_q, d_d;
  logic [K_W-1:0]    k_q, k_d;
  logic [OUT_W-1:0]  acc_q, acc_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic [OUT_W-1:0]  pp [PP_N];

  // One partial product per multiplier bit; unused table slots contribute zero.
  for (genvar gi = 0; gi < PP_N; gi++) begin : g_pp
    if (gi < K_W) begin : g_bit
      assign pp[gi] = k_q[gi] ? (OUT_W'(d_q) << gi) : '0;
    end else begin : g_pad
      assign pp[gi] = '0;
    end
  end

  // sum is the accumulator value after the step performed at this edge.
  assign sum       = acc_q + pp[step_q];
  assign last_step = (step_q == STEP_W'(CALC_CYCLES - 1));
`ifdef MUL_SCHED_ZERO_SKIP_EN
  assign zero_op   = (d_q == '0) || (k_q == '0);
`endif

  // Next-state: capture clears the accumulator, each enabled step adds.
  always_comb begin
    d_d    = d_q;
    k_d    = k_q;
    acc_d  = acc_q;
    step_d = step_q;
    if (start) begin
      d_d    = d;
      k_d    = k;
      acc_d  = '0;
      step_d = '0;
    end else if (step_en) begin
      acc_d  = sum;
      step_d = step_q + 1'b1;
    end
  end

  // Operand, accumulator and step registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_q    <= '0;
      k_q    <= '0;
      acc_q  <= '0;
      step_q <= '0;
    end else begin
      d_q    <= d_d;
      k_q    <= k_d;
      acc_q  <= acc_d;
      step_q <= step_d;
    end
  end

endmodule

// File: rtl/mul_sched.sv
// mul_sched: round-robin scheduler in front of a 3-step shift-add multiplier.
// IDLE/DONE capture a request, CALC runs the core, DONE presents the result.
// Optional build macro MUL_SCHED_ZERO_SKIP_EN: a zero operand finishes after
// the first CALC cycle with a zero result.
module mul_sched
  import mul_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [D_W-1:0]   d0,
  input  logic [K_W-1:0]   k0,
  output logic             gnt0,
  input  logic             req1,
  input  logic [D_W-1:0]   d1,
  input  logic [K_W-1:0]   k1,
  output logic             gnt1,
  output logic [OUT_W-1:0] out,
  output logic             out_valid,
  output logic             out_id,
  output logic             busy
);

  state_t           state_q, state_d;
  logic             last_q, last_d;      // last granted requester
  logic             win_q, win_d;        // owner of the in-flight operation
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             out_valid_q, out_valid_d;
  logic             out_id_q, out_id_d;

  logic             win;
  logic             start;
  logic             step_en;
  logic             finish;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] result;
  logic             last_step;
  logic [D_W-1:0]   cap_d;
  logic [K_W-1:0]   cap_k;

  // Round-robin: on a tie the requester not granted last wins.
  assign win   = (req0 && req1) ? ~last_q : req1;
  assign cap_d = win ? d1 : d0;
  assign cap_k = win ? k1 : k0;

`ifdef MUL_SCHED_ZERO_SKIP_EN
  logic zero_op;
  assign finish = zero_op || last_step;
  assign result = zero_op ? '0 : sum;
`else
  assign finish = last_step;
  assign result = sum;
`endif

  mul_shift_core u_core (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .step_en   (step_en),
    .d         (cap_d),
    .k         (cap_k),
    .sum       (sum),
`ifdef MUL_SCHED_ZERO_SKIP_EN
    .zero_op   (zero_op),
`endif
    .last_step (last_step)
  );

  // FSM next-state, arbitration and output-register next values.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    win_d       = win_q;
    out_d       = out_q;
    out_id_d    = out_id_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    out_valid_d = 1'b0;
    start       = 1'b0;
    step_en     = 1'b0;
    case (state_q)
      ST_CALC: begin
        step_en = 1'b1;
        if (finish) begin
          state_d     = ST_DONE;
          out_d       = result;
          out_valid_d = 1'b1;
          out_id_d    = win_q;
        end
      end
      default: begin
        // IDLE and DONE both accept a new request back-to-back.
        if (req0 || req1) begin
          start   = 1'b1;
          state_d = ST_CALC;
          last_d  = win;
          win_d   = win;
          gnt0_d  = ~win;
          gnt1_d  = win;
        end else begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // State and registered outputs; reset overrides any request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      last_q      <= 1'b1;
      win_q       <= 1'b0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
      out_id_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      win_q       <= win_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
      out_id_q    <= out_id_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;
  assign out_id    = out_id_q;
  assign busy      = (state_q == ST_CALC) || (state_q == ST_DONE);

endmodule

// File: tb/tb_mul_sched.sv
// tb_mul_sched: directed and randomized checks of mul_sched against a
// product/round-robin reference model.
module tb_mul_sched;
  import mul_sched_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [D_W-1:0]   d0, d1;
  logic [K_W-1:0]   k0, k1;
  logic             gnt0, gnt1;
  logic [OUT_W-1:0] out;
  logic             out_valid, out_id, busy;

  int   tests = 0;
  int   fails = 0;
  logic last_m;   // model: last granted requester

  mul_sched dut (
    .clk(clk), .rst(rst),
    .req0(req0), .d0(d0), .k0(k0), .gnt0(gnt0),
    .req1(req1), .d1(d1), .k1(k1), .gnt1(gnt1),
    .out(out), .out_valid(out_valid), .out_id(out_id), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic void check(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Serve one operation with the current request inputs held.
  // keep=1: the winner immediately re-requests with fresh random operands.
  // exp_wait>=0: required number of cycles before the grant appears.
  task automatic serve(input bit keep, input int exp_wait);
    logic exp_id;
    int   exp_out, n, lat, exp_lat;
    exp_id  = (req0 && req1) ? ~last_m : req1;
    exp_out = exp_id ? int'(d1) * int'(k1) : int'(d0) * int'(k0);
    exp_lat = 3;
`ifdef MUL_SCHED_ZERO_SKIP_EN
    if (exp_out == 0) exp_lat = 1;
`endif
    n = 0;
    while (!(gnt0 || gnt1) && n < 8) begin
      tick();
      n++;
    end
    check("gnt_seen", 32'(gnt0 | gnt1), 32'd1);
    if (exp_wait >= 0) check("gnt_wait", 32'(n), 32'(exp_wait));
    check("gnt0", 32'(gnt0), 32'(!exp_id));
    check("gnt1", 32'(gnt1), 32'(exp_id));
    check("busy_calc", 32'(busy), 32'd1);
    last_m = exp_id;
    if (exp_id) begin
      if (keep) begin d1 = 8'($urandom); k1 = 3'($urandom); end
      else req1 = 1'b0;
    end else begin
      if (keep) begin d0 = 8'($urandom); k0 = 3'($urandom); end
      else req0 = 1'b0;
    end
    lat = 0;
    do begin
      tick();
      lat++;
      if (!out_valid && lat < 8) check("gnt_onecycle", 32'(gnt0 | gnt1), 32'd0);
    end while (!out_valid && lat < 8);
    check("out_valid_lat", 32'(lat), 32'(exp_lat));
    check("out", 32'(out), 32'(exp_out));
    check("out_id", 32'(out_id), 32'(exp_id));
    check("busy_done", 32'(busy), 32'd1);
    $display("[TB] op id=%0d out=%0d exp=%0d lat=%0d", out_id, out, exp_out, lat);
    tick();
    check("valid_pulse", 32'(out_valid), 32'd0);
    check("out_hold", 32'(out), 32'(exp_out));
  endtask

  initial begin
    int n;
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    d0 = '0; k0 = '0; d1 = '0; k1 = '0;
    last_m = 1'b1;
    tick(); tick();
    check("rst_out", 32'(out), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_id", 32'(out_id), 32'd0);
    check("rst_gnt", 32'({gnt1, gnt0}), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    tick();

    // Single requester, 10*7.
    d0 = 8'd10; k0 = 3'd7; req0 = 1'b1;
    serve(1'b0, 1);

    // Tie from reset: requester 0 first, requester 1 four cycles later.
    rst = 1'b1; tick(); rst = 1'b0; last_m = 1'b1;
    d0 = 8'd3; k0 = 3'd5; d1 = 8'd11; k1 = 3'd2;
    req0 = 1'b1; req1 = 1'b1;
    serve(1'b0, 1);
    serve(1'b0, 0);

    // Maximum product.
    d0 = 8'd255; k0 = 3'd7; req0 = 1'b1;
    serve(1'b0, 1);

    // Zero multiplier.
    d0 = 8'd20; k0 = 3'd0; req0 = 1'b1;
    serve(1'b0, 1);

    // Random request patterns and operands, drained to idle each round.
    for (int r = 0; r < 12; r++) begin
      d0 = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      k0 = 3'($urandom);
      d1 = 8'($urandom);
      k1 = ($urandom_range(0, 4) == 0) ? 3'd0 : 3'($urandom);
      case ($urandom_range(0, 2))
        0: begin req0 = 1'b1; req1 = 1'b0; end
        1: begin req0 = 1'b0; req1 = 1'b1; end
        default: begin req0 = 1'b1; req1 = 1'b1; end
      endcase
      n = 0;
      while ((req0 || req1) && n < 4) begin
        serve(1'b0, -1);
        n++;
      end
    end

    // Reset during CALC discards the operation; reset beats held requests.
    d0 = 8'd9; k0 = 3'd3; req0 = 1'b1;
    n = 0;
    while (!gnt0 && n < 8) begin tick(); n++; end
    check("mid_gnt0", 32'(gnt0), 32'd1);
    req0 = 1'b0;
    tick();
    rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
    d0 = 8'd6; k0 = 3'd6; d1 = 8'd7; k1 = 3'd1;
    tick();
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_out", 32'(out), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    tick();
    check("rst_over_gnt", 32'({gnt1, gnt0}), 32'd0);
    check("rst_over_valid", 32'(out_valid), 32'd0);
    rst = 1'b0; last_m = 1'b1;
    serve(1'b0, 1);
    serve(1'b0, 0);

    // Sustained requests for 16 cycles: alternating grants every 4 cycles.
    d0 = 8'($urandom); k0 = 3'($urandom); d1 = 8'($urandom); k1 = 3'($urandom);
    req0 = 1'b1; req1 = 1'b1;
    serve(1'b1, 1);
    for (int s = 0; s < 3; s++) serve(1'b1, 0);
    n = 0;
    while ((req0 || req1) && n < 4) begin
      serve(1'b0, 0);
      n++;
    end
    tick();
    check("final_idle", 32'(busy), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mul_sched.md
MUL_SCHED -- requirements
Module: mul_sched

Interface
- REQ-001: The block SHALL have no parameters; all widths SHALL come from mul_sched_pkg.
- REQ-002: clk  input  1  sole clock, all state updates on rising edge.
- REQ-003: rst  input  1  reset, synchronous, active-high.
- REQ-004: req0  input  1  requester 0 operation request, held until gnt0 seen.
- REQ-005: d0  input  8  requester 0 multiplicand, unsigned.
- REQ-006: k0  input  3  requester 0 multiplier, unsigned.
- REQ-007: gnt0  output  1  one-cycle pulse, requester 0 operands were captured.
- REQ-008: req1, d1, k1, gnt1  SHALL be identical in direction, width and meaning to the requester 0 ports, for requester 1.
- REQ-009: out  output  11  product d*k of last completed operation.
- REQ-010: out_valid  output  1  one-cycle pulse, out holds a new result.
- REQ-011: out_id  output  1  requester index owning the current out.
- REQ-012: busy  output  1  high in CALC and DONE states.

Function
- REQ-013: FSM states SHALL be IDLE, CALC and DONE.
- REQ-014: IDLE SHALL capture operands at a rising edge when any req is high, then enter CALC.
- REQ-015: Capture SHALL register d, k and the winner index, and SHALL clear the accumulator.
- REQ-016: The granted requester's gnt SHALL be high for exactly the one cycle following the capture edge.
- REQ-017: At most one gnt SHALL be high in any cycle.
- REQ-018: Arbitration SHALL be round-robin.
  - Sole requester: always granted.
  - Both requesting: the requester not granted last wins.
  - Pointer SHALL update only on capture.
- REQ-019: CALC SHALL last exactly 3 cycles, step i = 0,1,2.
  - If k[i]=1, acc SHALL add (d << i).
  - Arithmetic SHALL be unsigned and 11 bits wide, with no overflow (max 255*7 = 1785).
- REQ-020: On the third CALC step the FSM SHALL enter DONE.
  - In DONE: out = acc, out_valid = 1 and out_id = winner, for one cycle.
- REQ-021: out and out_id SHALL hold until the next DONE.
- REQ-022: DONE with any req high SHALL capture per REQ-014/018 and go directly to CALC; otherwise it SHALL go to IDLE.
  - Sustained requests SHALL yield one result per 4 cycles.
- REQ-023: Latency SHALL be: capture edge, gnt in cycle 1, out_valid in cycle 4 after the capture edge.
- REQ-024: A req dropped before its grant SHALL be ignored, and a req asserted during CALC SHALL wait.

Reset
- REQ-025: On rst high at a clock edge, the block SHALL:
  - enter state IDLE;
  - set out=0, out_id=0, out_valid=0, gnt0=gnt1=0, busy=0;
  - set the last-granted pointer to 1, so requester 0 wins the first tie.
- REQ-026: rst mid-operation SHALL discard the in-flight operation with no out_valid, and rst SHALL override all requests in that cycle.

Configuration
- REQ-027: With MUL_SCHED_ZERO_SKIP_EN defined, a capture with d==0 or k==0 SHALL skip CALC and go directly to DONE with out=0.
  - Latency SHALL be out_valid in the cycle after gnt.
- REQ-028: Without MUL_SCHED_ZERO_SKIP_EN, every operation SHALL take the full 3-cycle CALC.

Structure
- REQ-029: mul_sched_pkg SHALL hold:
  - the state encoding (IDLE, CALC, DONE);
  - D_W=8, K_W=3, OUT_W=11;
  - CALC_CYCLES=3.
- REQ-030: Sub-module mul_shift_core SHALL hold the accumulator and step counter, with inputs start/d/k, and SHALL do the shift-add.
- REQ-031: mul_sched SHALL keep the FSM, arbiter and output registers.

Verification
- REQ-032: Req0 only, d0=10, k0=7 -> gnt0 one cycle, then out_valid 3 cycles later, out=70, out_id=0.
- REQ-033: Both req from reset, d0=3/k0=5 and d1=11/k1=2 -> gnt0 first, out=15/id0, then gnt1 4 cycles later, out=22/id1.
- REQ-034: d0=255, k0=7 -> out=1785, no truncation.
- REQ-035: rst pulsed during CALC -> no out_valid, out=0; then tie req0/req1 -> gnt0 wins.
- REQ-036: Both req held 16 cycles -> gnt alternates 0,1,0,1 with one out_valid every 4 cycles.
- REQ-037: d0=20, k0=0 -> with MUL_SCHED_ZERO_SKIP_EN, out_valid in the cycle after gnt0, out=0; without it, out_valid 3 cycles after gnt0, out=0.
